// File: rtl/serial_sub_ctrl_if.sv
// Request/result bundle between a requester and the bit-serial subtractor.
// The requester drives start and the operands; the subtractor returns
// its status and the registered result.
interface serial_sub_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  modport master (
    output start,
    output a,
    output b,
    input  busy,
    input  done,
    input  diff,
    input  borrow
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    output busy,
    output done,
    output diff,
    output borrow
  );
endinterface

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor controller: computes a - b one bit per clock,
// LSB first, through a single 1-bit full-subtractor cell and a registered
// borrow. A three-state FSM sequences the cell; results are held in
// output registers until the next operation completes.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  serial_sub_ctrl_if.slave bus
);

  localparam int                 CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Operand shifters feed the cell from bit 0; the result shifter collects
  // WIDTH-1 bits and the final bit is merged in when the result is loaded.
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] r_sh;
  logic [WIDTH-1:0] r_cat;
  logic             brw;
  logic [CNT_W-1:0] cnt;
  logic             last_bit;

  logic             cell_x;
  logic             cell_y;
  logic             cell_z;
  logic             cell_d;
  logic             cell_b;

  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             busy_c;
  logic             done_c;

  // Single full-subtractor cell: difference and borrow-out for one bit.
  always_comb begin
    cell_x = a_sh[0];
    cell_y = b_sh[0];
    cell_z = brw;
    cell_d = cell_x ^ cell_y ^ cell_z;
    cell_b = (~cell_x & cell_y) | (~cell_x & cell_z) | (cell_y & cell_z);
    r_cat  = {cell_d, r_sh};
    last_bit = (cnt == LAST_BIT);
  end

  // Next-state and status decode; DONE lasts exactly one cycle.
  always_comb begin
    state_nxt = state;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy_c = 1'b1;
        if (last_bit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy_c    = 1'b1;
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand capture, per-bit shifting and result loading on the final bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      r_sh     <= '0;
      brw      <= 1'b0;
      cnt      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh <= bus.a;
            b_sh <= bus.b;
            brw  <= 1'b0;
            cnt  <= '0;
          end
        end
        RUN: begin
          brw  <= cell_b;
          r_sh <= r_cat[WIDTH-1:1];
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          cnt  <= cnt + CNT_ONE;
          if (last_bit) begin
            diff_q   <= r_cat;
            borrow_q <= cell_b;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy   = busy_c;
  assign bus.done   = done_c;
  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl. Expected {borrow,diff} values
// are computed from the operands and queued when an operation is started,
// then popped and compared when done is observed.
module tb_serial_sub_ctrl;

  localparam int WIDTH = 8;
  localparam int BOUND = 40;

  logic clk = 1'b0;
  logic rst = 1'b0;

  serial_sub_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_sub_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [WIDTH:0] exp_q[$];
  logic [WIDTH:0] last_result = '0;
  logic [7:0]     corners [6] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFE, 8'hFF};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_expect(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    exp_q.push_back({1'b0, av} - {1'b0, bv});
  endtask

  task automatic wait_done(input int lat0, output int lat, output bit busy_ok,
                           output bit held_ok, output bit timed_out);
    lat = lat0;
    busy_ok = 1'b1;
    held_ok = 1'b1;
    timed_out = 1'b0;
    while (bus.done !== 1'b1) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if ({bus.borrow, bus.diff} !== last_result) held_ok = 1'b0;
      if (lat >= BOUND) begin
        timed_out = 1'b1;
        return;
      end
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    #2 rst = 1'b1;
    #1;
    n_compared++;
    if (bus.busy !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy);
    end
    n_compared++;
    if (bus.done !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL reset_done: got %b expected 0", bus.done);
    end
    n_compared++;
    if (bus.diff !== 8'h00) begin
      n_mismatched++; $display("[TB] FAIL reset_diff: got %h expected 00", bus.diff);
    end
    n_compared++;
    if (bus.borrow !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL reset_borrow: got %b expected 0", bus.borrow);
    end
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int lat;
    bit busy_ok, held_ok, to;
    logic [WIDTH:0] got, e;
    bus.a = 8'h05;
    bus.b = 8'h03;
    push_expect(bus.a, bus.b);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_done(1, lat, busy_ok, held_ok, to);
    n_compared++;
    if (to) begin
      n_mismatched++; $display("[TB] FAIL basic_timeout: no done within %0d edges", BOUND);
      return;
    end
    n_compared++;
    if (lat !== WIDTH + 1) begin
      n_mismatched++; $display("[TB] FAIL basic_latency: got %0d edges expected %0d", lat, WIDTH + 1);
    end
    n_compared++;
    if (!busy_ok || bus.busy !== 1'b1) begin
      n_mismatched++; $display("[TB] FAIL basic_busy: busy dropped while running, got %b at done expected 1", bus.busy);
    end
    n_compared++;
    if (!held_ok) begin
      n_mismatched++; $display("[TB] FAIL basic_held: result changed before done, expected %h", last_result);
    end
    got = {bus.borrow, bus.diff};
    n_compared++;
    if (exp_q.size() == 0) begin
      n_mismatched++; $display("[TB] FAIL basic_result: got %h expected (queue empty)", got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e || got !== 9'h002) begin
        n_mismatched++; $display("[TB] FAIL basic_result: got %h expected %h", got, e);
      end
    end
    last_result = got;
    step();
    n_compared++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL basic_after_done: got busy=%b done=%b expected 0/0", bus.busy, bus.done);
    end
  endtask

  task automatic test_borrow_cases();
    logic [7:0] ta [5] = '{8'h03, 8'h00, 8'h00, 8'hFF, 8'hFF};
    logic [7:0] tb [5] = '{8'h05, 8'h01, 8'h00, 8'hFF, 8'h00};
    int lat;
    bit busy_ok, held_ok, to;
    logic [WIDTH:0] got, e;
    for (int i = 0; i < 5; i++) begin
      bus.a = ta[i];
      bus.b = tb[i];
      push_expect(bus.a, bus.b);
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      wait_done(1, lat, busy_ok, held_ok, to);
      n_compared++;
      if (to) begin
        n_mismatched++; $display("[TB] FAIL table_timeout[%0d]: no done within %0d edges", i, BOUND);
        return;
      end
      n_compared++;
      if (lat !== WIDTH + 1 || !busy_ok || !held_ok) begin
        n_mismatched++;
        $display("[TB] FAIL table_timing[%0d]: got lat=%0d busy_ok=%b held_ok=%b expected %0d/1/1",
                 i, lat, busy_ok, held_ok, WIDTH + 1);
      end
      got = {bus.borrow, bus.diff};
      n_compared++;
      if (exp_q.size() == 0) begin
        n_mismatched++; $display("[TB] FAIL table_result[%0d]: got %h expected (queue empty)", i, got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_mismatched++; $display("[TB] FAIL table_result[%0d]: got %h expected %h", i, got, e);
        end
      end
      last_result = got;
      step();
    end
  endtask

  task automatic test_ignored_start();
    int lat;
    bit busy_ok, held_ok, to;
    logic [WIDTH:0] got, e;
    bus.a = 8'h10;
    bus.b = 8'h01;
    push_expect(bus.a, bus.b);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    bus.a = 8'h00;
    bus.b = 8'hFF;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_done(4, lat, busy_ok, held_ok, to);
    n_compared++;
    if (to) begin
      n_mismatched++; $display("[TB] FAIL ignore_timeout: no done within %0d edges", BOUND);
      return;
    end
    n_compared++;
    if (lat !== WIDTH + 1) begin
      n_mismatched++; $display("[TB] FAIL ignore_latency: got %0d edges expected %0d", lat, WIDTH + 1);
    end
    got = {bus.borrow, bus.diff};
    n_compared++;
    if (exp_q.size() == 0) begin
      n_mismatched++; $display("[TB] FAIL ignore_result: got %h expected (queue empty)", got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        n_mismatched++; $display("[TB] FAIL ignore_result: got %h expected %h", got, e);
      end
    end
    last_result = got;
    step();
    step();
    n_compared++;
    if (bus.busy !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL ignore_no_restart: got busy=%b expected 0", bus.busy);
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    bit busy_ok, held_ok, to;
    logic [WIDTH:0] got, e;
    bus.a = 8'hA5;
    bus.b = 8'h5A;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    #1;
    n_compared++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.diff !== 8'h00 || bus.borrow !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL abort_outputs: got busy=%b done=%b diff=%h borrow=%b expected 0/0/00/0",
               bus.busy, bus.done, bus.diff, bus.borrow);
    end
    step();
    n_compared++;
    if (bus.done !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL abort_done: got %b expected 0", bus.done);
    end
    rst = 1'b0;
    last_result = '0;
    step();
    bus.a = 8'h37;
    bus.b = 8'h12;
    push_expect(bus.a, bus.b);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_done(1, lat, busy_ok, held_ok, to);
    n_compared++;
    if (to) begin
      n_mismatched++; $display("[TB] FAIL abort_timeout: no done within %0d edges", BOUND);
      return;
    end
    got = {bus.borrow, bus.diff};
    n_compared++;
    if (exp_q.size() == 0) begin
      n_mismatched++; $display("[TB] FAIL abort_recover: got %h expected (queue empty)", got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e || lat !== WIDTH + 1 || !held_ok) begin
        n_mismatched++;
        $display("[TB] FAIL abort_recover: got %h lat=%0d held_ok=%b expected %h lat=%0d held_ok=1",
                 got, lat, held_ok, e, WIDTH + 1);
      end
    end
    last_result = got;
    step();
  endtask

  task automatic set_pair(input int i);
    if (i < 36) begin
      bus.a = corners[i / 6];
      bus.b = corners[i % 6];
    end else begin
      bus.a = 8'($urandom);
      bus.b = 8'($urandom);
    end
    push_expect(bus.a, bus.b);
  endtask

  task automatic test_back_to_back();
    int n_ops = 36 + 500;
    int gap;
    logic [WIDTH:0] got, e;
    set_pair(0);
    bus.start = 1'b1;
    for (int i = 0; i < n_ops; i++) begin
      gap = 0;
      do begin
        step();
        gap++;
      end while (bus.done !== 1'b1 && gap < BOUND);
      n_compared++;
      if (bus.done !== 1'b1) begin
        n_mismatched++; $display("[TB] FAIL b2b_timeout[%0d]: no done within %0d edges", i, BOUND);
        bus.start = 1'b0;
        return;
      end
      n_compared++;
      if (gap !== ((i == 0) ? WIDTH + 1 : WIDTH + 2)) begin
        n_mismatched++;
        $display("[TB] FAIL b2b_spacing[%0d]: got %0d edges expected %0d", i, gap,
                 (i == 0) ? WIDTH + 1 : WIDTH + 2);
      end
      got = {bus.borrow, bus.diff};
      n_compared++;
      if (exp_q.size() == 0) begin
        n_mismatched++; $display("[TB] FAIL b2b_result[%0d]: got %h expected (queue empty)", i, got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_mismatched++; $display("[TB] FAIL b2b_result[%0d]: got %h expected %h", i, got, e);
        end
      end
      last_result = got;
      if (i + 1 < n_ops) begin
        set_pair(i + 1);
      end else begin
        bus.start = 1'b0;
      end
    end
    step();
    step();
    n_compared++;
    if (bus.busy !== 1'b0 || {bus.borrow, bus.diff} !== last_result) begin
      n_mismatched++;
      $display("[TB] FAIL b2b_idle: got busy=%b result=%h expected 0 %h",
               bus.busy, {bus.borrow, bus.diff}, last_result);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow_cases();
    test_ignored_start();
    test_reset_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
